// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg: shared state encoding and default truth-table constants for the sweep driver
package tt_sweep_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
    localparam int TT_W = 8;
    localparam logic [TT_W-1:0] TT_EXPECTED = 8'h17;
endpackage

// File: rtl/tt_sweep_driver.sv
// tt_sweep_driver: sweeps every input vector of a combinational block, builds its truth table and checks it; TT_FIRST_FAIL_EN adds a first-failing-index report
module tt_sweep_driver
    import tt_sweep_pkg::*;
#(
    parameter int N_IN = 3,
    parameter int SETTLE_CYC = 1,
    parameter logic [2**N_IN-1:0] EXPECTED_TT = (2**N_IN)'(TT_EXPECTED)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 y_in,
    output logic [N_IN-1:0]      vec_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   truth_table,
`ifdef TT_FIRST_FAIL_EN
    output logic                 fail_valid,
    output logic [N_IN-1:0]      fail_idx,
`endif
    output logic                 pass
);
    localparam logic [N_IN-1:0] LAST = '1;
    state_t state, state_d;
    logic [3:0] cnt;
    logic [2**N_IN-1:0] tt_next;
    logic go;
    assign go = state == IDLE && start;
    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_d;
    // next state and the table as it will look after the current sample
    always_comb begin
        state_d = go ? DRIVE :
                  (state == DRIVE && cnt == 4'(SETTLE_CYC - 1)) ? SAMPLE :
                  state == SAMPLE ? (vec_out == LAST ? DONE : DRIVE) :
                  state == DONE ? IDLE : state;
        tt_next = truth_table;
        tt_next[vec_out] = y_in;
    end
    // datapath: registered status flags, settle counter, vector index and captured table
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            vec_out     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            truth_table <= '0;
            pass        <= 1'b0;
            cnt         <= '0;
        end else begin
            busy <= state_d == DRIVE || state_d == SAMPLE;
            done <= state_d == DONE;
            if (go) begin
                truth_table <= '0;
                pass        <= 1'b0;
                vec_out     <= '0;
                cnt         <= '0;
            end
            if (state == DRIVE) cnt <= cnt + 4'd1;
            if (state == SAMPLE) begin
                truth_table <= tt_next;
                cnt         <= '0;
                if (vec_out != LAST) vec_out <= vec_out + N_IN'(1);
                else pass <= tt_next == EXPECTED_TT;
            end
        end
`ifdef TT_FIRST_FAIL_EN
    // latch only the first vector whose sample disagrees with the expected table
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            fail_valid <= 1'b0;
            fail_idx   <= '0;
        end else if (go) begin
            fail_valid <= 1'b0;
            fail_idx   <= '0;
        end else if (state == SAMPLE && !fail_valid && y_in != EXPECTED_TT[vec_out]) begin
            fail_valid <= 1'b1;
            fail_idx   <= vec_out;
        end
`endif
endmodule
